// File: rtl/snes_pad_hub.sv
// snes_pad_hub
//   Polls NUM_PADS SNES controllers in parallel over one shared latch/clock
//   pair derived from the system clock. Each frame latches the pads, shifts
//   BITS bits from every pad at once, then commits the inverted (active-high)
//   words to `buttons` in a single cycle flagged by `frame_valid`.
//
//   Optional feature macro: SNES_HUB_EDGE_EN
//     Adds sticky new-press flags (`pressed`) and their clear (`pressed_clr`).
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   snes_data    [NUM_PADS]       serial data per pad (active-low, async)
//   snes_latch   shared latch to all pads (registered)
//   snes_clk     shared shift clock, idles high (registered)
//   buttons      [NUM_PADS*BITS]  pad p at [p*BITS +: BITS], 1 = pressed
//   frame_valid  one-cycle pulse when buttons updates
//   pressed      [NUM_PADS*BITS]  sticky new-press flags (SNES_HUB_EDGE_EN)
//   pressed_clr  clears all pressed flags (SNES_HUB_EDGE_EN)
module snes_pad_hub #(
  parameter int NUM_PADS    = 2,
  parameter int BITS        = 16,
  parameter int TICK_DIV    = 300,
  parameter int FRAME_TICKS = 2778
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_PADS-1:0]      snes_data,
  output logic                     snes_latch,
  output logic                     snes_clk,
  output logic [NUM_PADS*BITS-1:0] buttons,
  output logic                     frame_valid
`ifdef SNES_HUB_EDGE_EN
  ,
  output logic [NUM_PADS*BITS-1:0] pressed,
  input  logic                     pressed_clr
`endif
);

  localparam int P_W      = $clog2(TICK_DIV);
  localparam int T_W      = $clog2(FRAME_TICKS);
  localparam int COMMIT_T = 2 + 2 * BITS;

  logic [P_W-1:0]           pre;
  logic [T_W-1:0]           t;
  logic [NUM_PADS-1:0]      data_p0;
  logic [NUM_PADS-1:0]      data_p1;
  logic [NUM_PADS*BITS-1:0] shift_q;

  logic pre_last;
  logic latch_phase;
  logic clk_low_phase;
  logic commit;

  assign pre_last      = (pre == P_W'(TICK_DIV - 1));
  assign latch_phase   = (t < T_W'(2));
  // Even ticks inside the shift window drive the pad clock low.
  assign clk_low_phase = (t >= T_W'(2)) && (t < T_W'(COMMIT_T)) && !t[0];
  // First cycle of the first idle tick: every bit of the frame is in.
  assign commit        = (t == T_W'(COMMIT_T)) && (pre == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre         <= '0;
      t           <= '0;
      data_p0     <= '0;
      data_p1     <= '0;
      shift_q     <= '0;
      snes_latch  <= 1'b0;
      snes_clk    <= 1'b1;
      buttons     <= '0;
      frame_valid <= 1'b0;
`ifdef SNES_HUB_EDGE_EN
      pressed     <= '0;
`endif
    end else begin
      // Stage p0/p1: two-flop synchroniser on the asynchronous pad lines
      data_p0 <= snes_data;
      data_p1 <= data_p0;

      // Tick timebase: prescaler then frame tick index
      if (pre_last) begin
        pre <= '0;
        t   <= (t == T_W'(FRAME_TICKS - 1)) ? '0 : t + T_W'(1);
      end else begin
        pre <= pre + P_W'(1);
      end

      // Pad-facing outputs registered from the current tick (glitch-free)
      snes_latch <= latch_phase;
      snes_clk   <= !clk_low_phase;

      // Sample on the last cycle of each low tick, just before the rising edge
      for (int p = 0; p < NUM_PADS; p++) begin
        for (int i = 0; i < BITS; i++) begin
          if (pre_last && (t == T_W'(2 + 2 * i)))
            shift_q[p*BITS + i] <= data_p1[p];
        end
      end

      // Commit stage: whole frame becomes visible at once
      frame_valid <= commit;
      if (commit)
        buttons <= ~shift_q;

`ifdef SNES_HUB_EDGE_EN
      // Clear first, then newly pressed bits set, so a coincident new press survives.
      if (commit)
        pressed <= (pressed_clr ? '0 : pressed) | (~shift_q & ~buttons);
      else if (pressed_clr)
        pressed <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_snes_pad_hub.sv
module tb_snes_pad_hub;

  localparam int NP = 2;
  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NP-1:0] snes_data;
  logic          snes_latch;
  logic          snes_clk;
  logic [31:0]   buttons;
  logic          frame_valid;
`ifdef SNES_HUB_EDGE_EN
  logic [31:0]   pressed;
  logic          pressed_clr = 1'b0;
`endif

  snes_pad_hub #(
    .NUM_PADS(NP), .BITS(NB), .TICK_DIV(4), .FRAME_TICKS(40)
  ) dut (
    .clk(clk),
    .reset(reset),
    .snes_data(snes_data),
    .snes_latch(snes_latch),
    .snes_clk(snes_clk),
    .buttons(buttons),
    .frame_valid(frame_valid)
`ifdef SNES_HUB_EDGE_EN
    ,
    .pressed(pressed),
    .pressed_clr(pressed_clr)
`endif
  );

  always #5 clk = ~clk;

  // Edge count since reset release: cycle n is the interval after edge n.
  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Pad model: latch reloads bit 0, each rising snes_clk advances one bit;
  // past the last bit the line floats high. Data is active-low.
  logic [15:0] pat0 = 16'h0000;
  logic [15:0] pat1 = 16'h0000;
  logic [4:0]  idx = 5'd0;
  always @(posedge snes_latch or posedge snes_clk) begin
    if (snes_latch)        idx <= 5'd0;
    else if (idx != 5'd16) idx <= idx + 5'd1;
  end
  assign snes_data[0] = (idx < 5'd16) ? ~pat0[idx[3:0]] : 1'b1;
  assign snes_data[1] = (idx < 5'd16) ? ~pat1[idx[3:0]] : 1'b1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] btn;
    logic [31:0] prs;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic [31:0] btn, input logic [31:0] prs, input int c);
    exp_t e;
    e.btn = btn; e.prs = prs; e.cyc = c;
    sb.push_back(e);
  endtask

  int epoch = 0;
  int stray = 0;
  int lat_err = 0;
  int clk_err = 0;
  int pulses = 0;
  logic [31:0] prev_btn = '0;
  logic        prev_clk = 1'b1;

  function automatic logic exp_latch(input int c);
    int tk;
    tk = ((c - 1) % 160) / 4;
    return tk < 2;
  endfunction

  function automatic logic exp_sclk(input int c);
    int tk;
    tk = ((c - 1) % 160) / 4;
    return !(tk >= 2 && tk < 34 && (tk % 2) == 0);
  endfunction

  // Monitor: pops the scoreboard on every frame_valid, watches for stray updates.
  always @(negedge clk) begin
    exp_t e;
    if (reset && frame_valid) begin
      if (sb.size() == 0) begin
        check("fv_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("buttons", buttons, e.btn);
        check("fv_cycle", 32'(cyc), 32'(e.cyc));
`ifdef SNES_HUB_EDGE_EN
        check("pressed", pressed, e.prs);
`endif
      end
    end
    if (reset && !frame_valid && buttons !== prev_btn) stray <= stray + 1;
    prev_btn <= buttons;
    if (epoch == 1 && cyc >= 1 && cyc <= 320) begin
      if (snes_latch !== exp_latch(cyc)) lat_err <= lat_err + 1;
      if (snes_clk !== exp_sclk(cyc))    clk_err <= clk_err + 1;
      if (cyc <= 160 && prev_clk && !snes_clk) pulses <= pulses + 1;
    end
    prev_clk <= snes_clk;
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_latch"}, {31'd0, snes_latch}, 32'd0);
    check({tag, "_sclk"}, {31'd0, snes_clk}, 32'd1);
    check({tag, "_buttons"}, buttons, 32'd0);
    check({tag, "_fv"}, {31'd0, frame_valid}, 32'd0);
`ifdef SNES_HUB_EDGE_EN
    check({tag, "_pressed"}, pressed, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Epoch 1: idle pads, then patterns, then a mid-shift change
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    push(32'h0000_0000, 32'h0000_0000, 137);
    push(32'h0000_0000, 32'h0000_0000, 297);
    epoch = 1;
    reset = 1'b1;
    wait_cyc(300);
    pat0 = 16'hA5F0;
    pat1 = 16'h0001;
    push(32'h0001_A5F0, 32'h0001_A5F0, 457);
    push(32'h0001_3CF0, 32'h0001_BDF0, 617);
    push(32'h0001_3C3C, 32'h0001_BDFC, 777);
    // Bit 7 of frame 4 is sampled at edge 548, bit 8 at 556.
    wait_cyc(550);
    pat0 = 16'h3C3C;
    wait_cyc(790);
    check("latch_wave_errs", 32'(lat_err), 32'd0);
    check("sclk_wave_errs", 32'(clk_err), 32'd0);
    check("sclk_low_pulses", 32'(pulses), 32'd16);

    // Epoch 2: one good frame, then reset during bit 10 of frame 2
    epoch = 2;
    reset = 1'b0;
    pat0 = 16'h1234;
    pat1 = 16'h8000;
    repeat (3) @(negedge clk);
    push(32'h8000_1234, 32'h8000_1234, 137);
    reset = 1'b1;
    wait_cyc(250);
    reset = 1'b0;
    #1;
    check_reset_state("midrst");
    repeat (4) @(negedge clk);
    check("midrst_fv_hold", {31'd0, frame_valid}, 32'd0);
    check("midrst_btn_hold", buttons, 32'd0);

    // Epoch 3: bit 3 held for three frames, bit 5 joins on frame 4
    epoch = 3;
    pat0 = 16'h0008;
    pat1 = 16'h0000;
    push(32'h0000_0008, 32'h0000_0008, 137);
    push(32'h0000_0008, 32'h0000_0008, 297);
    push(32'h0000_0008, 32'h0000_0008, 457);
    push(32'h0000_0028, 32'h0000_0020, 617);
    reset = 1'b1;
    wait_cyc(460);
    pat0 = 16'h0028;
    wait_cyc(616);
`ifdef SNES_HUB_EDGE_EN
    pressed_clr = 1'b1;
`endif
    wait_cyc(617);
`ifdef SNES_HUB_EDGE_EN
    pressed_clr = 1'b0;
`endif
    wait_cyc(640);
    check("buttons_stray_changes", 32'(stray), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
